md_ctrl: RTL and testbench
==========================

# md_ctrl

Multiply/divide sequencing controller for the E stage of the five-stage pipeline. It accepts mult/multu/div/divu/mthi/mtlo operations issued with the ALU operands, and owns the HI/LO register pair. It models multi-cycle latency with a countdown state machine. It raises a stall request so the hazard unit freezes PC/Dreg and clears Ereg while a multiply/divide-class instruction sits in D.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  input  1  pipeline clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset; clears all state immediately
- md_start  input  1  E-stage instruction is an md operation; sampled each rising edge
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved (ignored)
- md_srca  input  32  forwarded rs value (MF_RS_E)
- md_srcb  input  32  forwarded rt value (MF_RT_E)
- d_md_use  input  1  D-stage instruction is md-class (mult/div/mfhi/mflo/mthi/mtlo)
- md_busy  output  1  operation in flight
- md_stall  output  1  stall request to hazard unit
- md_hi  output  32  architectural HI
- md_lo  output  32  architectural LO

## Operation
- States: IDLE, BUSY. The counter cnt is wide enough for max(MULT_CYCLES, DIV_CYCLES).
- IDLE, md_start=1, op 0–3:
  - capture the result into shadow registers res_hi/res_lo, computed from the md_srca/md_srcb present at that edge;
  - load cnt with MULT_CYCLES or DIV_CYCLES;
  - go to BUSY.
- BUSY: cnt decrements each edge. When cnt=1 at an edge, HI/LO ← res_hi/res_lo and the state returns to IDLE.
- IDLE, md_start=1, op 4/5: HI (MTHI) or LO (MTLO) ← md_srca at that edge. No busy period.
- md_start in BUSY is ignored; hazard logic guarantees it never occurs. Reserved ops are ignored.
- MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned 64-bit product.
- DIV (signed):
  - LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU: unsigned LO = quotient, HI = remainder.
- Divide by zero (srcb=0, op 2/3): a full DIV_CYCLES busy period runs, then HI/LO remain unchanged.
- md_busy = (state==BUSY).
- md_stall = d_md_use & (md_busy | (md_start & op∈{0..3})). Combinational.
- Reset low at any time: state=IDLE, cnt=0, HI=LO=0, shadows=0. Any in-flight result is discarded.

## Timing
- Reset values: md_busy=0, md_stall=0 (given d_md_use=0), md_hi=0, md_lo=0.
- Start accepted at edge T0. md_busy is high from T0+ through the edge T0+N (N = cycle parameter), inclusive of N cycles.
- New HI/LO are visible after edge T0+N, in the same cycle md_busy drops.
- mfhi/mflo read md_hi/md_lo combinationally. The stall guarantees a reader never sees a stale value.
- MTHI/MTLO: the value is visible the cycle after the accepting edge.
- Back-to-back: a new start is legal on the edge where busy drops only if it comes from an E-stage instruction. Accepting it returns the state to BUSY with no idle gap.
- Operands are sampled only at the accepting edge. Later changes to md_srca/md_srcb have no effect.

## Test plan
- Reset, then release; issue MULT srca=0xFFFFFFFE(-2) srcb=3 → md_busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7/2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU 7/0 → 10 busy cycles, HI/LO unchanged.
- d_md_use=1 held during a DIV → md_stall high from the start cycle through the final busy cycle, low the cycle after. With d_md_use=0, md_stall stays 0.
- MTLO 0x12345678, then MTHI 0xCAFEBABE on consecutive edges → LO and HI each update one cycle after issue, with md_busy never asserted.
- Pull reset low mid-MULT (cnt=3) → md_busy, HI, LO go to 0 immediately. After release, a new MULT behaves normally.

Source files
------------

// File: rtl/md_ctrl_if.sv
// Multiply/divide controller bus: E-stage issue, D-stage use flag, and HI/LO/status back.
interface md_ctrl_if;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_srca;
    logic [31:0] md_srcb;
    logic        d_md_use;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    modport slave (
        input  md_start, md_op, md_srca, md_srcb, d_md_use,
        output md_busy, md_stall, md_hi, md_lo
    );

    modport master (
        output md_start, md_op, md_srca, md_srcb, d_md_use,
        input  md_busy, md_stall, md_hi, md_lo
    );
endinterface

// File: rtl/md_ctrl.sv
// Multiply/divide sequencing controller: owns HI/LO, models multi-cycle latency
// with a countdown, and requests a pipeline stall while md-class work is pending.
module md_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_ctrl_if.slave  bus
);
    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        res_hi_q, res_hi_d, res_lo_q, res_lo_d;

    logic [31:0]        a, b;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               a_neg, b_neg, b_zero;
    logic [31:0]        a_mag, b_mag, b_mag_nz, b_nz;
    logic [31:0]        uq_s, ur_s, q_s, r_s, q_u, r_u;
    logic               accept;

    assign a = bus.md_srca;
    assign b = bus.md_srcb;

    // Datapath: both products and both quotients from the live operands.
    // Signed divide works on magnitudes so MIN_INT / -1 wraps cleanly to MIN_INT.
    always_comb begin
        prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u   = {32'b0, a} * {32'b0, b};
        a_neg    = a[31];
        b_neg    = b[31];
        b_zero   = (b == '0);
        a_mag    = a_neg ? (~a + 32'd1) : a;
        b_mag    = b_neg ? (~b + 32'd1) : b;
        b_mag_nz = b_zero ? 32'd1 : b_mag;
        b_nz     = b_zero ? 32'd1 : b;
        uq_s     = a_mag / b_mag_nz;
        ur_s     = a_mag % b_mag_nz;
        q_s      = (a_neg ^ b_neg) ? (~uq_s + 32'd1) : uq_s;
        r_s      = a_neg ? (~ur_s + 32'd1) : ur_s;
        q_u      = a / b_nz;
        r_u      = a % b_nz;
    end

    // State register with immediate asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    // Next state: count down, commit on the last busy edge, then accept a new op
    // on that same edge (back-to-back) or whenever idle. A new MTHI/MTLO on the
    // commit edge is younger than the finishing op, so it overrides the commit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        accept   = (state_q == IDLE) || (cnt_q == CNT_W'(1));

        if (state_q == BUSY) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                hi_d    = res_hi_q;
                lo_d    = res_lo_q;
                state_d = IDLE;
            end
        end

        if (accept && bus.md_start) begin
            unique case (bus.md_op)
                OP_MULT, OP_MULTU: begin
                    res_hi_d = (bus.md_op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                    res_lo_d = (bus.md_op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
                    cnt_d    = CNT_W'(MULT_CYCLES);
                    state_d  = BUSY;
                end
                OP_DIV, OP_DIVU: begin
                    // Divide by zero reloads the shadows with the HI/LO that will
                    // be architectural after this edge, so the commit is a no-op.
                    if (b_zero) begin
                        res_hi_d = hi_d;
                        res_lo_d = lo_d;
                    end else begin
                        res_hi_d = (bus.md_op == OP_DIV) ? r_s : r_u;
                        res_lo_d = (bus.md_op == OP_DIV) ? q_s : q_u;
                    end
                    cnt_d   = CNT_W'(DIV_CYCLES);
                    state_d = BUSY;
                end
                OP_MTHI: hi_d = a;
                OP_MTLO: lo_d = a;
                default: ;
            endcase
        end
    end

    assign bus.md_busy  = (state_q == BUSY);
    assign bus.md_stall = bus.d_md_use & (bus.md_busy | (bus.md_start & ~bus.md_op[2]));
    assign bus.md_hi    = hi_q;
    assign bus.md_lo    = lo_q;
endmodule

// File: tb/tb_md_ctrl.sv
// Bench for md_ctrl: directed scenarios plus randomized ops against a
// cycle-level behavioural model of HI/LO, latency and stall.
module tb_md_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_ctrl_if bus();

    md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: remaining busy cycles, pending result, architectural HI/LO.
    int          m_left;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_valid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_valid = 0;
    endtask

    // Apply the architectural rules for one rising edge.
    task automatic model_edge(input bit st, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b);
        bit          acc;
        longint      sp;
        longint unsigned up;
        int          sa, sb;
        acc = (m_left <= 1);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_valid) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end
        if (st && acc) begin
            case (op)
                3'd0: begin
                    sp = longint'($signed(a)) * longint'($signed(b));
                    p_hi = sp[63:32]; p_lo = sp[31:0]; p_valid = 1; m_left = MC;
                end
                3'd1: begin
                    up = longint'({32'b0, a}) * longint'({32'b0, b});
                    p_hi = up[63:32]; p_lo = up[31:0]; p_valid = 1; m_left = MC;
                end
                3'd2, 3'd3: begin
                    m_left = DC;
                    p_valid = (b != 0);
                    if (b != 0) begin
                        if (op == 3'd3) begin
                            p_lo = a / b; p_hi = a % b;
                        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                            p_lo = 32'h8000_0000; p_hi = '0;
                        end else begin
                            sa = a; sb = b;
                            p_lo = sa / sb; p_hi = sa % sb;
                        end
                    end
                end
                3'd4: m_hi = a;
                3'd5: m_lo = a;
                default: ;
            endcase
        end
    endtask

    // One cycle: drive inputs, compare outputs against the model, take the edge.
    task automatic step(input bit st, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit use_d);
        bus.md_start = st; bus.md_op = op; bus.md_srca = a; bus.md_srcb = b; bus.d_md_use = use_d;
        #1;
        chk("busy",  64'(bus.md_busy),  64'(m_left > 0));
        chk("stall", 64'(bus.md_stall), 64'(use_d && (m_left > 0 || (st && op < 3'd4))));
        chk("hi",    64'(bus.md_hi),    64'(m_hi));
        chk("lo",    64'(bus.md_lo),    64'(m_lo));
        @(posedge clk);
        model_edge(st, op, a, b);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit use_d);
        for (int i = 0; i < n; i++) step(0, 3'd0, $urandom, $urandom, use_d);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.md_start = 0; bus.md_op = '0; bus.md_srca = '0; bus.md_srcb = '0; bus.d_md_use = 0;
        reset = 1'b0;
        model_reset();
        #2;
        chk("rst_busy",  64'(bus.md_busy),  64'd0);
        chk("rst_stall", 64'(bus.md_stall), 64'd0);
        chk("rst_hi",    64'(bus.md_hi),    64'd0);
        chk("rst_lo",    64'(bus.md_lo),    64'd0);
        @(negedge clk);
        reset = 1'b1;

        // MULT -2 * 3
        step(1, 3'd0, 32'hFFFF_FFFE, 32'd3, 0);
        idle(MC, 0);
        chk("mult_hi", 64'(bus.md_hi), 64'h0000_0000_FFFF_FFFF);
        chk("mult_lo", 64'(bus.md_lo), 64'h0000_0000_FFFF_FFFA);

        // MULTU max * max
        step(1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        idle(MC, 0);
        chk("multu_hi", 64'(bus.md_hi), 64'h0000_0000_FFFF_FFFE);
        chk("multu_lo", 64'(bus.md_lo), 64'h0000_0000_0000_0001);

        // DIV -7 / 2 with d_md_use held, then DIVU by zero
        step(1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1);
        idle(DC, 1);
        idle(1, 1);
        chk("div_lo", 64'(bus.md_lo), 64'h0000_0000_FFFF_FFFD);
        chk("div_hi", 64'(bus.md_hi), 64'h0000_0000_FFFF_FFFF);
        step(1, 3'd3, 32'd7, 32'd0, 0);
        idle(DC, 0);
        chk("div0_lo", 64'(bus.md_lo), 64'h0000_0000_FFFF_FFFD);
        chk("div0_hi", 64'(bus.md_hi), 64'h0000_0000_FFFF_FFFF);

        // MTLO then MTHI on consecutive edges
        step(1, 3'd5, 32'h1234_5678, 32'd0, 0);
        chk("mtlo_lo", 64'(bus.md_lo), 64'h0000_0000_1234_5678);
        step(1, 3'd4, 32'hCAFE_BABE, 32'd0, 0);
        chk("mthi_hi", 64'(bus.md_hi), 64'h0000_0000_CAFE_BABE);
        idle(1, 0);

        // Signed overflow divide
        step(1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        idle(DC, 0);
        chk("ovf_lo", 64'(bus.md_lo), 64'h0000_0000_8000_0000);
        chk("ovf_hi", 64'(bus.md_hi), 64'h0);

        // Back-to-back: second MULT on the edge where busy drops
        step(1, 3'd0, 32'd6, 32'd7, 0);
        idle(MC - 1, 0);
        step(1, 3'd1, 32'd100, 32'd3, 0);
        chk("b2b_busy", 64'(bus.md_busy), 64'd1);
        chk("b2b_lo1",  64'(bus.md_lo),   64'd42);
        idle(MC, 0);
        chk("b2b_lo2",  64'(bus.md_lo),   64'd300);

        // Reset mid-MULT (cnt=3), then a fresh MULT
        step(1, 3'd0, 32'd9, 32'd9, 0);
        idle(2, 0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(bus.md_busy), 64'd0);
        chk("mid_rst_hi",   64'(bus.md_hi),   64'd0);
        chk("mid_rst_lo",   64'(bus.md_lo),   64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(1, 3'd0, 32'hFFFF_FFFF, 32'd5, 0);
        idle(MC, 0);
        chk("post_rst_lo", 64'(bus.md_lo), 64'h0000_0000_FFFF_FFFB);
        chk("post_rst_hi", 64'(bus.md_hi), 64'h0000_0000_FFFF_FFFF);

        // Randomized traffic; starts while busy are ignored by the model too.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)),
                 rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
        end
        idle(DC + 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
